task_dispatcher_mc: RTL and testbench

Multi-lane, parametrised task generator for the PoW miner core array. It issues up to LANES nonce-incremented rdata tasks per cycle over a valid/ready handshake, and counts round acknowledgements. It requests a first-block midstate from an external single-round hasher, and refreshes that midstate automatically when the counter carry reaches the first-block bytes. It sits between the host register block and the core array, replacing the single-lane generator.

---
 rtl/task_dispatcher_mc.sv | 199 +++++++++++++++++++
 tb/tb_task_dispatcher_mc.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/task_dispatcher_mc.sv
// Multi-lane PoW task generator: issues nonce-incremented rdata beats, counts round acks and
// requests a fresh first-block midstate whenever the counter carry reaches the first-block bytes.
module task_dispatcher_mc #(
  parameter int unsigned CORES_QNT = 4,
  parameter int unsigned LANES     = 2,
  parameter int unsigned CNT_W     = 64,
  parameter int unsigned FB_BYTES  = 3,
  parameter int unsigned ACK_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_n_reset,
  input  logic                 i_start_nf,
  input  logic [511:0]         i_start_rdata,
  input  logic                 i_gen_term,
  output logic                 o_ms_start,
  output logic [511:0]         o_ms_rdata,
  input  logic                 i_ms_rf,
  input  logic [255:0]         i_ms_sha256,
  output logic [255:0]         o_state,
  output logic                 o_state_valid,
  output logic                 o_task_valid,
  input  logic                 i_task_ready,
  output logic [LANES-1:0]     o_task_lane_en,
  output logic [15:0]          o_task_core_num,
  output logic [LANES*512-1:0] o_task_rdata,
  input  logic                 i_tasks_sr_ack,
  output logic [ACK_W-1:0]     o_tasks_srs_acks_qnt,
  output logic                 o_bf
);
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StMsWait  = 3'd1;
  localparam logic [2:0] StIssue   = 3'd2;
  localparam logic [2:0] StWaitAck = 3'd3;
  localparam logic [2:0] StRefresh = 3'd4;

  localparam int unsigned FbW      = 8 * FB_BYTES;
  localparam logic [16:0] CoresQnt = 17'(CORES_QNT);
  localparam logic [2:0]  LanesQnt = 3'(LANES);

  logic [2:0]       state_q, state_d;
  logic [511:0]     base_q, base_d;
  logic [511:0]     ms_rdata_q, ms_rdata_d;
  logic             ms_start_q, ms_start_d;
  logic [255:0]     st_q, st_d;
  logic             st_valid_q, st_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      core_num_q, core_num_d;
  logic [ACK_W-1:0] acks_q, acks_d;

  // Byte 0 sits in bits [7:0] but is the most significant byte of the integer.
  function automatic logic [511:0] byte_rev(input logic [511:0] v);
    logic [511:0] r;
    for (int k = 0; k < 64; k++) r[8*k +: 8] = v[8*(63-k) +: 8];
    return r;
  endfunction

  logic [LANES*512-1:0] lane_rdata;
  logic [LANES-1:0]     lane_en;
  logic [2:0]           n_en;
  logic [511:0]         base_int, lane_int, lane_vec;
  logic                 prev_en;
  logic [255:0]         sha_rev;

  always_comb begin
    base_int   = byte_rev(base_q);
    lane_rdata = '0;
    lane_en    = '0;
    n_en       = '0;
    prev_en    = 1'b1;
    lane_int   = '0;
    lane_vec   = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_int = base_int + 512'(cnt_q) + 512'(l);
      lane_vec = byte_rev(lane_int);
      lane_rdata[512*l +: 512] = lane_vec;
      // Lanes stay contiguous: once one lane drops out, all higher lanes drop too.
      lane_en[l] = prev_en && (({1'b0, core_num_q} + 17'(l)) < CoresQnt) &&
                   (lane_vec[FbW-1:0] == ms_rdata_q[FbW-1:0]);
      prev_en = lane_en[l];
      n_en    = n_en + 3'(lane_en[l]);
    end
  end

  always_comb begin
    sha_rev = '0;
    for (int w = 0; w < 8; w++) begin
      sha_rev[32*w +: 32] = {i_ms_sha256[32*w +: 8], i_ms_sha256[32*w+8 +: 8],
                             i_ms_sha256[32*w+16 +: 8], i_ms_sha256[32*w+24 +: 8]};
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    ms_rdata_d = ms_rdata_q;
    ms_start_d = 1'b0;
    st_d       = st_q;
    st_valid_d = st_valid_q;
    cnt_d      = cnt_q;
    core_num_d = core_num_q;
    acks_d     = acks_q;
    if (i_gen_term) begin
      state_d    = StIdle;
      st_valid_d = 1'b0;
      cnt_d      = '0;
      core_num_d = '0;
      acks_d     = '0;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_d      = '0;
          core_num_d = '0;
          acks_d     = '0;
          if (i_start_nf) begin
            base_d     = i_start_rdata;
            ms_rdata_d = i_start_rdata;
            ms_start_d = 1'b1;
            state_d    = StMsWait;
          end
        end
        StMsWait: begin
          if (i_ms_rf) begin
            st_d       = sha_rev;
            st_valid_d = 1'b1;
            state_d    = StIssue;
          end
        end
        StIssue: begin
          if (!lane_en[0]) begin
            if ({1'b0, core_num_q} < CoresQnt) state_d = StRefresh;
          end else if (i_task_ready) begin
            cnt_d      = cnt_q + CNT_W'(n_en);
            core_num_d = core_num_q + 16'(n_en);
            if (({1'b0, core_num_q} + 17'(n_en)) == CoresQnt) state_d = StWaitAck;
            else if (n_en < LanesQnt)                         state_d = StRefresh;
          end
        end
        StWaitAck: begin
          if (i_tasks_sr_ack) begin
            acks_d     = acks_q + 1'b1;
            core_num_d = '0;
            state_d    = StIssue;
          end
        end
        StRefresh: begin
          // A partial round must be acknowledged before the midstate changes under it.
          if (core_num_q != '0) begin
            if (i_tasks_sr_ack) begin
              acks_d     = acks_q + 1'b1;
              core_num_d = '0;
            end
          end else begin
            st_valid_d = 1'b0;
            ms_rdata_d = lane_rdata[511:0];
            ms_start_d = 1'b1;
            state_d    = StMsWait;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state_q    <= StIdle;
      base_q     <= '0;
      ms_rdata_q <= '0;
      ms_start_q <= 1'b0;
      st_q       <= '0;
      st_valid_q <= 1'b0;
      cnt_q      <= '0;
      core_num_q <= '0;
      acks_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      ms_rdata_q <= ms_rdata_d;
      ms_start_q <= ms_start_d;
      st_q       <= st_d;
      st_valid_q <= st_valid_d;
      cnt_q      <= cnt_d;
      core_num_q <= core_num_d;
      acks_q     <= acks_d;
    end
  end

  assign o_ms_start           = ms_start_q;
  assign o_ms_rdata           = ms_rdata_q;
  assign o_state              = st_q;
  assign o_state_valid        = st_valid_q;
  assign o_task_valid         = (state_q == StIssue) && lane_en[0];
  assign o_task_lane_en       = (state_q == StIssue) ? lane_en : '0;
  assign o_task_rdata         = (state_q == StIssue) ? lane_rdata : '0;
  assign o_task_core_num      = core_num_q;
  assign o_tasks_srs_acks_qnt = acks_q;
  assign o_bf                 = (state_q != StIdle);

endmodule

// File: tb/tb_task_dispatcher_mc.sv
// Scoreboard bench for task_dispatcher_mc: expected beats and midstate requests are queued by
// the stimulus and popped by negedge monitors whenever the DUT presents them.
module tb_task_dispatcher_mc;
  typedef struct packed {
    logic [1:0]    en;
    logic [15:0]   core;
    logic [1023:0] rdata;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           start, gen_term, ms_rf, ready, ack;
  logic [511:0]   start_rdata;
  logic [255:0]   sha;
  logic           ms_start, st_valid, t_valid, bf;
  logic [511:0]   ms_rdata;
  logic [255:0]   st;
  logic [1:0]     lane_en;
  logic [15:0]    core_num, acks;
  logic [1023:0]  t_rdata;

  logic           b_start, b_ms_rf, b_ready, b_ack;
  logic           b_ms_start, b_st_valid, b_t_valid, b_bf;
  logic [511:0]   b_ms_rdata;
  logic [255:0]   b_st;
  logic [1:0]     b_lane_en;
  logic [15:0]    b_core_num, b_acks;
  logic [1023:0]  b_t_rdata;

  int    checks = 0;
  int    errors = 0;
  beat_t qa[$];
  beat_t qb[$];
  logic [511:0] qms[$];
  logic  a_stall = 1'b0;
  beat_t a_hold;

  task_dispatcher_mc #(
    .CORES_QNT(4), .LANES(2), .CNT_W(64), .FB_BYTES(3), .ACK_W(16)
  ) u_dut (
    .i_clk(clk), .i_n_reset(rst_n), .i_start_nf(start), .i_start_rdata(start_rdata),
    .i_gen_term(gen_term), .o_ms_start(ms_start), .o_ms_rdata(ms_rdata), .i_ms_rf(ms_rf),
    .i_ms_sha256(sha), .o_state(st), .o_state_valid(st_valid), .o_task_valid(t_valid),
    .i_task_ready(ready), .o_task_lane_en(lane_en), .o_task_core_num(core_num),
    .o_task_rdata(t_rdata), .i_tasks_sr_ack(ack), .o_tasks_srs_acks_qnt(acks), .o_bf(bf)
  );

  task_dispatcher_mc #(
    .CORES_QNT(3), .LANES(2), .CNT_W(64), .FB_BYTES(3), .ACK_W(16)
  ) u_dut_b (
    .i_clk(clk), .i_n_reset(rst_n), .i_start_nf(b_start), .i_start_rdata(512'd0),
    .i_gen_term(1'b0), .o_ms_start(b_ms_start), .o_ms_rdata(b_ms_rdata), .i_ms_rf(b_ms_rf),
    .i_ms_sha256(sha), .o_state(b_st), .o_state_valid(b_st_valid), .o_task_valid(b_t_valid),
    .i_task_ready(b_ready), .o_task_lane_en(b_lane_en), .o_task_core_num(b_core_num),
    .o_task_rdata(b_t_rdata), .i_tasks_sr_ack(b_ack), .o_tasks_srs_acks_qnt(b_acks),
    .o_bf(b_bf)
  );

  function automatic logic [511:0] vec(input logic [511:0] x);
    logic [511:0] r;
    for (int k = 0; k < 64; k++) r[8*k +: 8] = x[8*(63-k) +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s got %0d want %0d", name, act, exp);
  endtask

  // Lane 1 always carries lane-0 value + 1, enabled or not.
  task automatic push_a(input logic [1:0] en, input logic [15:0] core, input logic [511:0] x);
    beat_t b;
    b.en = en;
    b.core = core;
    b.rdata = {vec(x + 512'd1), vec(x)};
    qa.push_back(b);
  endtask

  task automatic push_b(input logic [1:0] en, input logic [15:0] core, input logic [511:0] x);
    beat_t b;
    b.en = en;
    b.core = core;
    b.rdata = {vec(x + 512'd1), vec(x)};
    qb.push_back(b);
  endtask

  always @(negedge clk) begin
    if (!rst_n || gen_term) begin
      a_stall <= 1'b0;
    end else begin
      if (a_stall) begin
        check("a_hold_valid", 512'(t_valid), 512'd1);
        check("a_hold_en", 512'(lane_en), 512'(a_hold.en));
        check("a_hold_core", 512'(core_num), 512'(a_hold.core));
        check("a_hold_rdata0", t_rdata[511:0], a_hold.rdata[511:0]);
      end
      if (t_valid && ready) begin
        if (qa.size() == 0) begin
          fail("a_beat_extra_core", int'(core_num), -1);
        end else begin
          check("a_beat_en", 512'(lane_en), 512'(qa[0].en));
          check("a_beat_core", 512'(core_num), 512'(qa[0].core));
          check("a_beat_rdata0", t_rdata[511:0], qa[0].rdata[511:0]);
          check("a_beat_rdata1", t_rdata[1023:512], qa[0].rdata[1023:512]);
          void'(qa.pop_front());
        end
      end
      a_stall <= t_valid && !ready;
      a_hold  <= {lane_en, core_num, t_rdata};
    end
    if (rst_n && ms_start) begin
      if (qms.size() == 0) begin
        fail("a_ms_extra", 1, 0);
      end else begin
        check("a_ms_rdata", ms_rdata, qms[0]);
        void'(qms.pop_front());
      end
    end
    if (rst_n && b_t_valid && b_ready) begin
      if (qb.size() == 0) begin
        fail("b_beat_extra_core", int'(b_core_num), -1);
      end else begin
        check("b_beat_en", 512'(b_lane_en), 512'(qb[0].en));
        check("b_beat_core", 512'(b_core_num), 512'(qb[0].core));
        check("b_beat_rdata0", b_t_rdata[511:0], qb[0].rdata[511:0]);
        check("b_beat_rdata1", b_t_rdata[1023:512], qb[0].rdata[1023:512]);
        void'(qb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic start_a(input logic [511:0] rd);
    start_rdata = rd;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Hasher model: waits for the request, then answers after a fixed latency.
  task automatic midstate_a();
    int n = 0;
    while (!ms_start && n < 30) begin
      tick();
      n++;
    end
    if (!ms_start) fail("a_ms_start_timeout", 0, 1);
    check("a_ms_wait_state_valid", 512'(st_valid), 512'd0);
    tick();
    tick();
    ms_rf = 1'b1;
    tick();
    ms_rf = 1'b0;
    check("a_state_valid_set", 512'(st_valid), 512'd1);
  endtask

  task automatic drain_a();
    int n = 0;
    while (qa.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (qa.size() != 0) fail("a_drain_timeout_pending", qa.size(), 0);
  endtask

  task automatic drain_b();
    int n = 0;
    while (qb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (qb.size() != 0) fail("b_drain_timeout_pending", qb.size(), 0);
  endtask

  initial begin
    logic [511:0] bi;
    int n;
    start = 1'b0; gen_term = 1'b0; ms_rf = 1'b0; ready = 1'b0; ack = 1'b0;
    start_rdata = '0; sha = {8{32'h11223344}};
    b_start = 1'b0; b_ms_rf = 1'b0; b_ready = 1'b0; b_ack = 1'b0;

    // Reset state
    #2;
    check("rst_valid", 512'(t_valid), 512'd0);
    check("rst_bf", 512'(bf), 512'd0);
    check("rst_ms_start", 512'(ms_start), 512'd0);
    check("rst_state_valid", 512'(st_valid), 512'd0);
    check("rst_acks", 512'(acks), 512'd0);
    check("rst_lane_en", 512'(lane_en), 512'd0);
    check("rst_core_num", 512'(core_num), 512'd0);
    check("rst_rdata1", t_rdata[1023:512], 512'd0);
    check("rst_ms_rdata", ms_rdata, 512'd0);
    #10 rst_n = 1'b1;
    tick();

    // Basic round, base 0
    ready = 1'b1;
    qms.push_back(512'd0);
    push_a(2'b11, 16'd0, 512'd0);
    push_a(2'b11, 16'd2, 512'd2);
    start_a(512'd0);
    check("ms_start_latency", 512'(ms_start), 512'd1);
    check("busy_after_start", 512'(bf), 512'd1);
    midstate_a();
    check("state_word_swap", 512'(st), 512'({8{32'h44332211}}));
    drain_a();
    tick();
    tick();
    check("wait_ack_valid", 512'(t_valid), 512'd0);
    check("wait_ack_busy", 512'(bf), 512'd1);
    push_a(2'b11, 16'd0, 512'd4);
    push_a(2'b11, 16'd2, 512'd6);
    pulse_ack();
    check("acks_one", 512'(acks), 512'd1);
    drain_a();

    // Backpressure on the first beat of round 3
    ready = 1'b0;
    push_a(2'b11, 16'd0, 512'd8);
    push_a(2'b11, 16'd2, 512'd10);
    pulse_ack();
    repeat (5) tick();
    check("bp_valid_held", 512'(t_valid), 512'd1);
    check("bp_acks", 512'(acks), 512'd2);
    ready = 1'b1;
    drain_a();

    // Abort coinciding with a handshake
    ready = 1'b0;
    pulse_ack();
    n = 0;
    while (!t_valid && n < 10) begin
      tick();
      n++;
    end
    if (!t_valid) fail("abort_valid_timeout", 0, 1);
    ready = 1'b1;
    gen_term = 1'b1;
    tick();
    gen_term = 1'b0;
    check("abort_valid", 512'(t_valid), 512'd0);
    check("abort_bf", 512'(bf), 512'd0);
    check("abort_acks", 512'(acks), 512'd0);
    check("abort_state_valid", 512'(st_valid), 512'd0);
    check("abort_queue_untouched", 512'(qa.size()), 512'd0);

    // Restart: counter begins again at 0 relative to the new base
    qms.push_back(vec(512'd16));
    push_a(2'b11, 16'd0, 512'd16);
    push_a(2'b11, 16'd2, 512'd18);
    start_a(vec(512'd16));
    midstate_a();
    drain_a();
    tick();

    // Asynchronous reset while waiting for the round ack
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", 512'(t_valid), 512'd0);
    check("arst_bf", 512'(bf), 512'd0);
    check("arst_state_valid", 512'(st_valid), 512'd0);
    check("arst_state", 512'(st), 512'd0);
    check("arst_ms_rdata", ms_rdata, 512'd0);
    #2 rst_n = 1'b1;
    tick();
    pulse_ack();
    tick();
    check("arst_ack_ignored_bf", 512'(bf), 512'd0);
    check("arst_ack_ignored_acks", 512'(acks), 512'd0);
    check("arst_ack_ignored_valid", 512'(t_valid), 512'd0);

    // First-block refresh: bytes 0..2 = 00, bytes 3..63 = FF
    bi = {24'h0, {488{1'b1}}};
    qms.push_back(vec(bi));
    qms.push_back(512'h010000);
    push_a(2'b01, 16'd0, bi);
    start_a(vec(bi));
    midstate_a();
    drain_a();
    tick();
    tick();
    check("refresh_wait_valid", 512'(t_valid), 512'd0);
    check("refresh_wait_state_valid", 512'(st_valid), 512'd1);
    check("refresh_wait_core", 512'(core_num), 512'd1);
    push_a(2'b11, 16'd0, bi + 512'd1);
    push_a(2'b11, 16'd2, bi + 512'd3);
    pulse_ack();
    check("refresh_acks", 512'(acks), 512'd1);
    midstate_a();
    drain_a();

    // Uneven tail on the 3-core instance
    b_ready = 1'b1;
    push_b(2'b11, 16'd0, 512'd0);
    push_b(2'b01, 16'd2, 512'd2);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("b_ms_start", 512'(b_ms_start), 512'd1);
    check("b_ms_rdata", b_ms_rdata, 512'd0);
    tick();
    b_ms_rf = 1'b1;
    tick();
    b_ms_rf = 1'b0;
    check("b_state", 512'(b_st), 512'({8{32'h44332211}}));
    drain_b();
    tick();
    check("b_wait_ack_valid", 512'(b_t_valid), 512'd0);
    check("b_wait_ack_busy", 512'(b_bf), 512'd1);
    push_b(2'b11, 16'd0, 512'd3);
    push_b(2'b01, 16'd2, 512'd5);
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    check("b_acks", 512'(b_acks), 512'd1);
    check("b_state_valid", 512'(b_st_valid), 512'd1);
    drain_b();
    tick();
    check("a_ms_queue_empty", 512'(qms.size()), 512'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got 1 want 0");
    $fatal(1);
  end

endmodule
